sd_bd_queue: RTL and testbench
==============================

SD_BD_QUEUE -- requirements
Module: sd_bd_queue

Interface
REQ-001 SHALL have parameter BD_DEPTH, default 8, number of buffer-descriptor slots (power of two, 2..16).
REQ-002 SHALL have parameter BD_WIDTH, default 5, width of the free-slot count; it SHALL hold values 0..BD_DEPTH.
REQ-003 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-low reset.
REQ-005 SHALL have port we_i  in  1  host write strobe, one 32-bit descriptor word per cycle.
REQ-006 SHALL have port dat_i  in  32  host write data.
REQ-007 SHALL have port new_bd  out  1  one-cycle pulse when a descriptor commits.
REQ-008 SHALL have port free_bd  out  BD_WIDTH  number of free descriptor slots.
REQ-009 SHALL have port re_s  in  1  read request from the data master.
REQ-010 SHALL have port ack_o_s  out  1  halfword-valid strobe to the data master.
REQ-011 SHALL have port dat_o  out  16  halfword of the head descriptor.
REQ-012 SHALL have port a_cmp  in  1  transfer-complete pulse that frees the head slot.
REQ-013 SHALL have port ovf  out  1  sticky flag for a write dropped while full.
REQ-014 SHALL have port flush_i  in  1  queue flush; present only when BD_FLUSH_EN is defined.

Function
REQ-015 SHALL store each descriptor as two 32-bit words: word 0 is sys_adr and word 1 is cmd_arg.
REQ-016 SHALL track the host word position with a write-select bit wsel: a we_i with wsel=0 stores sys_adr into the tail slot, and a we_i with wsel=1 stores cmd_arg, commits the slot, advances the tail, and clears wsel.
REQ-017 SHALL, when free_bd==0 and wsel=0, drop a we_i, leave wsel at 0 and set ovf; ovf clears only on reset.
REQ-018 SHALL pulse new_bd high for exactly one cycle, in the cycle after a commit.
REQ-019 SHALL update free_bd in the cycle after a commit (decrement) or a head free (increment); if both occur in the same cycle, free_bd SHALL be unchanged.
REQ-020 SHALL define the head as valid when free_bd<BD_DEPTH, and SHALL keep a halfword index hidx in the range 0..3.
REQ-021 SHALL, when re_s=1, the head is valid and hidx<4 in cycle N, drive ack_o_s=1 in cycle N+1 with dat_o = sys_adr[15:0], sys_adr[31:16], cmd_arg[15:0] or cmd_arg[31:16] for hidx 0..3, and increment hidx.
REQ-022 SHALL, while re_s is held, deliver one ack per cycle, and SHALL issue no more than 4 acks per descriptor regardless of re_s.
REQ-023 SHALL, on a_cmp with a valid head, advance the head and reset hidx to 0; a_cmp with an empty queue SHALL be ignored.
REQ-024 SHALL hold dat_o stable when ack_o_s=0.
REQ-025 SHALL wrap the head and tail pointers modulo BD_DEPTH.

Reset
REQ-026 SHALL, on rst=0 at a clock edge, set free_bd=BD_DEPTH and set new_bd, ack_o_s, dat_o, ovf, wsel, hidx and both pointers to 0.
REQ-027 SHALL, on reset mid-read, abandon the read with no further ack_o_s; stored RAM contents need not clear.

Configuration
REQ-028 SHALL, with BD_FLUSH_EN defined, on flush_i=1 in cycle N, empty the queue in cycle N+1: free_bd=BD_DEPTH, wsel=0, hidx=0, ack_o_s=0, and ovf unchanged.
REQ-029 SHALL, with BD_FLUSH_EN defined, give flush_i priority over we_i and a_cmp in the same cycle.
REQ-030 SHALL, without BD_FLUSH_EN, have no flush_i port and no flush logic.

Verification
REQ-031 Write 0x00001000 then 0x00000020 -> new_bd pulses once; free_bd 8->7; re_s held -> 4 acks with dat_o 0x1000, 0x0000, 0x0020, 0x0000, then no further ack.
REQ-032 Write 8 descriptors, then a 9th sys_adr -> free_bd=0, ovf=1, wsel stays 0, contents unchanged.
REQ-033 Issue a_cmp and a commit in the same cycle at free_bd=3 -> free_bd stays 3, and the next head's halfwords read back correctly.
REQ-034 Run 20 write/read/a_cmp cycles -> pointers wrap correctly, and data is in order after the 8th descriptor.
REQ-035 Assert rst=0 after 2 acks -> next cycle ack_o_s=0, free_bd=8, and no ack follows with re_s still high.
REQ-036 With BD_FLUSH_EN, assert flush_i together with we_i (wsel=1) at free_bd=5 -> free_bd=8, no new_bd pulse.

Source files
------------

// File: rtl/sd_bd_queue.sv
// Buffer-descriptor queue: the host writes two-word descriptors, the data master reads the head as four halfwords.
// Optional flush input and flush logic are built only when BD_FLUSH_EN is defined.
module sd_bd_queue #(
   parameter int BD_DEPTH = 8,
   parameter int BD_WIDTH = 5
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we_i,
   input  logic [31:0]         dat_i,
   output logic                new_bd,
   output logic [BD_WIDTH-1:0] free_bd,
   input  logic                re_s,
   output logic                ack_o_s,
   output logic [15:0]         dat_o,
   input  logic                a_cmp,
   output logic                ovf
`ifdef BD_FLUSH_EN
   ,
   input  logic                flush_i
`endif
);

   localparam int PTR_W = (BD_DEPTH > 1) ? $clog2(BD_DEPTH) : 1;
   localparam logic [BD_WIDTH-1:0] DEPTH_V = BD_WIDTH'(BD_DEPTH);

   // Word address is {slot, word}: word 0 = sys_adr, word 1 = cmd_arg.
   logic [31:0]      ram [0:2*BD_DEPTH-1];

   logic [PTR_W-1:0] head_reg;
   logic [PTR_W-1:0] tail_reg;
   logic             wsel_reg;
   logic [1:0]       hidx_reg;
   logic             rd_done_reg;
   logic [31:0]      rd_word_reg;
   logic             hi_sel_reg;

   logic             flush;
   logic             head_valid;
   logic             full;
   logic             wr_en;
   logic             commit;
   logic             drop;
   logic             pop;
   logic             rd_fire;
   logic [PTR_W:0]   wr_addr;
   logic [PTR_W:0]   rd_addr;

`ifdef BD_FLUSH_EN
   assign flush = flush_i;
`else
   assign flush = 1'b0;
`endif

   assign head_valid = (free_bd != DEPTH_V);
   assign full       = (free_bd == '0);
   assign drop       = we_i && full && !wsel_reg && !flush;
   assign wr_en      = we_i && !(full && !wsel_reg) && !flush;
   assign commit     = wr_en && wsel_reg;
   assign pop        = a_cmp && head_valid && !flush;
   // rd_done_reg caps the head at four halfwords until a_cmp moves on.
   assign rd_fire    = re_s && head_valid && !rd_done_reg && !flush;
   assign wr_addr    = {tail_reg, wsel_reg};
   assign rd_addr    = {head_reg, hidx_reg[1]};

   always_ff @(posedge clk) begin
      if (wr_en)
         ram[wr_addr] <= dat_i;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_word_reg <= '0;
         hi_sel_reg  <= 1'b0;
      end else if (rd_fire) begin
         rd_word_reg <= ram[rd_addr];
         hi_sel_reg  <= hidx_reg[0];
      end
   end

   assign dat_o = hi_sel_reg ? rd_word_reg[31:16] : rd_word_reg[15:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         head_reg    <= '0;
         tail_reg    <= '0;
         wsel_reg    <= 1'b0;
         hidx_reg    <= 2'd0;
         rd_done_reg <= 1'b0;
         free_bd     <= DEPTH_V;
         new_bd      <= 1'b0;
         ack_o_s     <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         new_bd  <= commit;
         ack_o_s <= rd_fire;
         if (drop)
            ovf <= 1'b1;
         if (flush) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            wsel_reg    <= 1'b0;
            hidx_reg    <= 2'd0;
            rd_done_reg <= 1'b0;
            free_bd     <= DEPTH_V;
         end else begin
            if (wr_en) begin
               if (wsel_reg) begin
                  wsel_reg <= 1'b0;
                  tail_reg <= tail_reg + 1'b1;
               end else begin
                  wsel_reg <= 1'b1;
               end
            end
            if (pop) begin
               head_reg    <= head_reg + 1'b1;
               hidx_reg    <= 2'd0;
               rd_done_reg <= 1'b0;
            end else if (rd_fire) begin
               hidx_reg <= hidx_reg + 2'd1;
               if (hidx_reg == 2'd3)
                  rd_done_reg <= 1'b1;
            end
            // A simultaneous commit and head free cancel out.
            if (commit && !pop)
               free_bd <= free_bd - 1'b1;
            else if (pop && !commit)
               free_bd <= free_bd + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sd_bd_queue.sv
// Directed and random stimulus for sd_bd_queue, checked against a queue-of-descriptors reference model.
// Flush scenario is exercised only when BD_FLUSH_EN is defined.
module tb_sd_bd_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        we_i = 1'b0;
   logic [31:0] dat_i = '0;
   logic        re_s = 1'b0;
   logic        a_cmp = 1'b0;
   logic        new_bd;
   logic [4:0]  free_bd;
   logic        ack_o_s;
   logic [15:0] dat_o;
   logic        ovf;
`ifdef BD_FLUSH_EN
   logic        flush_i = 1'b0;
`endif

   always #5 clk = ~clk;

   sd_bd_queue #(.BD_DEPTH(DEPTH), .BD_WIDTH(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .we_i    (we_i),
      .dat_i   (dat_i),
      .new_bd  (new_bd),
      .free_bd (free_bd),
      .re_s    (re_s),
      .ack_o_s (ack_o_s),
      .dat_o   (dat_o),
      .a_cmp   (a_cmp),
      .ovf     (ovf)
`ifdef BD_FLUSH_EN
      ,
      .flush_i (flush_i)
`endif
   );

   // Reference model: committed descriptors as {cmd_arg, sys_adr}.
   logic [63:0] q[$];
   bit          m_wsel = 1'b0;
   logic [31:0] m_hold = '0;
   bit          m_ovf = 1'b0;
   int          m_acks = 0;
   logic [15:0] m_dat = '0;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input bit r, input bit w, input logic [31:0] d,
                       input bit re, input bit c, input bit fl);
      bit          e_new;
      bit          e_ack;
      bit          valid;
      bit          full;
      logic [63:0] h;
      rst   = r;
      we_i  = w;
      dat_i = d;
      re_s  = re;
      a_cmp = c;
`ifdef BD_FLUSH_EN
      flush_i = fl;
`endif
      e_new = 1'b0;
      e_ack = 1'b0;
      if (!r) begin
         q.delete();
         m_wsel = 1'b0;
         m_acks = 0;
         m_dat  = '0;
         m_ovf  = 1'b0;
      end else if (fl) begin
         q.delete();
         m_wsel = 1'b0;
         m_acks = 0;
      end else begin
         valid = (q.size() > 0);
         full  = (q.size() == DEPTH);
         if (re && valid && m_acks < 4) begin
            h     = q[0];
            e_ack = 1'b1;
            m_dat = h[16*m_acks +: 16];
            m_acks++;
         end
         if (c && valid) begin
            void'(q.pop_front());
            m_acks = 0;
         end
         if (w) begin
            if (!m_wsel && full) begin
               m_ovf = 1'b1;
            end else if (!m_wsel) begin
               m_hold = d;
               m_wsel = 1'b1;
            end else begin
               q.push_back({d, m_hold});
               m_wsel = 1'b0;
               e_new  = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      chk("new_bd",  32'(new_bd),  32'(e_new));
      chk("ack_o_s", 32'(ack_o_s), 32'(e_ack));
      chk("dat_o",   32'(dat_o),   32'(m_dat));
      chk("free_bd", 32'(free_bd), 32'(DEPTH - q.size()));
      chk("ovf",     32'(ovf),     32'(m_ovf));
   endtask

   task automatic wr_desc(input logic [31:0] sys, input logic [31:0] cmd);
      step(1'b1, 1'b1, sys, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, cmd, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      if (m_wsel)
         step(1'b1, 1'b1, $urandom, 1'b0, 1'b0, 1'b0);
      repeat (DEPTH + 1) step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      // Reset state
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Single descriptor, held read: exactly four halfwords
      wr_desc(32'h0000_1000, 32'h0000_0020);
      repeat (6) step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Fill to full, then overflow attempts are dropped
      for (int i = 0; i < DEPTH; i++)
         wr_desc($urandom, $urandom);
      step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
      repeat (5) step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Free down to 3, then commit and a_cmp together
      repeat (3) step(1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h9ABC_DEF0, 1'b0, 1'b1, 1'b0);
      repeat (5) step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      drain();

      // Reset in the middle of a read
      wr_desc(32'hA5A5_0001, 32'h5A5A_0002);
      repeat (2) step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      repeat (3) step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Random traffic: first biased toward filling, then toward draining
      repeat (200)
         step(1'b1, ($urandom_range(9) < 6), $urandom, ($urandom_range(9) < 7),
              ($urandom_range(7) == 0), 1'b0);
      repeat (200)
         step(1'b1, ($urandom_range(9) < 6), $urandom, ($urandom_range(9) < 7),
              ($urandom_range(2) == 0), 1'b0);
      drain();

`ifdef BD_FLUSH_EN
      // Flush with a pending cmd_arg write at free_bd=5
      for (int i = 0; i < 3; i++)
         wr_desc($urandom, $urandom);
      step(1'b1, 1'b1, 32'h0000_7777, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 32'h0000_8888, 1'b1, 1'b1, 1'b1);
      repeat (2) step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
      wr_desc(32'h0BAD_0001, 32'h0BAD_0002);
      repeat (5) step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
